count_controller: RTL

Sequencing controller for the team's binary counters: owns a WIDTH-bit count register and decides when it runs, holds, wraps and finishes. Accepts a start request with a programmable terminal count. Runs either one-shot or auto-reload, and reports status with a one-cycle Done pulse. Sits between control logic (buttons or top-level FSM) and any block that consumes a timed count.

---
 rtl/count_ctrl_pkg.sv | 13 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/count_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types and default sizing for the count controller.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ctrl_state_t;

  localparam int unsigned DEFAULT_WIDTH    = 3;
  localparam int unsigned DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Mod-PRESCALE divider: emits a one-cycle tick every PRESCALE enabled
// cycles. Clear restarts the period; the count freezes while enable is low.
module tick_prescaler
  import count_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] div_cnt;

  // Divider counter: clear wins, otherwise advance and wrap while enabled.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick = enable && !clear && (div_cnt == LAST);

endmodule

// File: rtl/count_controller.sv
// Sequencing controller around a WIDTH-bit count register: start with a
// captured terminal count, run one-shot or auto-reload, pause, abort.
// Optional macro COUNT_PRESCALE_EN: advance the count once every PRESCALE
// clocks through tick_prescaler; otherwise the count advances every clock.
module count_controller
  import count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Pause,
  input  logic             Abort,
  input  logic             Reload,
  input  logic [WIDTH-1:0] TermCount,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Held,
  output logic             Done
);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("count_controller: PRESCALE must be at least 2");
  end

  ctrl_state_t      state, state_next;
  logic [WIDTH-1:0] tc_q;
  logic             tick;
  logic             accept;
  logic             advance;
  logic             terminal;
  logic             busy_d, held_d, done_d;

  // Start only counts in IDLE; Abort overrides it.
  assign accept  = (state == IDLE) && Start && !Abort;
  // Pause freezes counting in RUN and HOLD alike, so leaving HOLD loses no tick.
  assign advance = (state != IDLE) && tick && !Pause && !Abort;
  assign terminal = advance && (Count == tc_q);

`ifdef COUNT_PRESCALE_EN
  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (accept || Abort),
    .enable ((state != IDLE) && !Pause && !Abort),
    .tick   (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: Abort > Pause > terminal/increment.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (Start) state_next = RUN;
      RUN, HOLD: begin
        if (terminal && !Reload) state_next = IDLE;
        else if (Pause)          state_next = HOLD;
        else                     state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
    if (Abort) state_next = IDLE;
  end

  // Output decode from the next state, registered below.
  always_comb begin
    busy_d = (state_next == RUN) || (state_next == HOLD);
    held_d = (state_next == HOLD);
    done_d = terminal;
  end

  // Registered status outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Busy <= 1'b0;
      Held <= 1'b0;
      Done <= 1'b0;
    end else begin
      Busy <= busy_d;
      Held <= held_d;
      Done <= done_d;
    end
  end

  // Count and captured terminal value.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Count <= '0;
      tc_q  <= '0;
    end else if (Abort) begin
      Count <= '0;
    end else if (accept) begin
      Count <= '0;
      tc_q  <= TermCount;
    end else if (advance) begin
      if (Count != tc_q) Count <= Count + 1'b1;
      else if (Reload)   Count <= '0;
    end
  end

endmodule
